// File: rtl/fir_tap_loader.sv
// ============================================================================
//  Module      : fir_tap_loader
//  Description : Streams a coefficient set into a shift-loaded FIR tap chain,
//                zero-filling short sets and discarding the excess of long ones.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_tap_loader #(
    parameter int TW    = 16,
    parameter int NTAPS = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [TW-1:0] s_data,
    input  logic          s_last,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int CW = $clog2(NTAPS + 1);
    localparam logic [CW-1:0] c_last_idx = CW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ZFILL   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t        r_state   = IDLE;
    logic [CW-1:0] r_cnt     = '0;
    logic          r_tap_wr  = 1'b0;
    logic [TW-1:0] r_tap     = '0;
    logic          r_done    = 1'b0;
    logic          r_err     = 1'b0;

    logic          w_accept;
    logic          w_final_idx;

    // Ready depends only on registered state, never on s_valid.
    assign s_ready     = (r_state == LOAD) || (r_state == DISCARD);
    assign w_accept    = s_valid && s_ready;
    assign w_final_idx = (r_cnt == c_last_idx);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_tap_wr <= 1'b0;
            r_tap    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_tap_wr <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_tap    <= s_data;
                        r_tap_wr <= 1'b1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_final_idx) begin
                            if (s_last) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= DISCARD;
                            end
                        end else if (s_last) begin
                            r_err   <= 1'b1;
                            r_state <= ZFILL;
                        end
                    end
                end
                ZFILL: begin
                    // Pad with zeros so every load shifts exactly NTAPS entries.
                    r_tap    <= '0;
                    r_tap_wr <= 1'b1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_final_idx) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (w_accept && s_last) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tap_wr = r_tap_wr;
    assign o_tap    = r_tap;
    assign o_busy   = (r_state != IDLE);
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_loader.sv
// ============================================================================
//  Module      : tb_fir_tap_loader
//  Description : Directed vector bench for fir_tap_loader (NTAPS=4, TW=16).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_tap_loader;

    localparam int TW    = 16;
    localparam int NTAPS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic [TW-1:0] data = '0;
    logic          last = 1'b0;
    logic          tap_wr;
    logic [TW-1:0] tap;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    fir_tap_loader #(.TW(TW), .NTAPS(NTAPS)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_start  (start),
        .s_valid  (valid),
        .s_ready  (ready),
        .s_data   (data),
        .s_last   (last),
        .o_tap_wr (tap_wr),
        .o_tap    (tap),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    // Inputs applied in a cycle, and the outputs expected during that same cycle
    typedef struct {
        logic          rst, start, valid;
        logic [TW-1:0] data;
        logic          last;
        logic          ready, wr;
        logic [TW-1:0] tap;
        logic          busy, done, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, st, v, input int d, input logic l,
                       input logic e_rdy, e_wr, input int e_tap,
                       input logic e_busy, e_done, e_err);
        vec_t x;
        x.rst = r; x.start = st; x.valid = v; x.data = TW'(d); x.last = l;
        x.ready = e_rdy; x.wr = e_wr; x.tap = TW'(e_tap);
        x.busy = e_busy; x.done = e_done; x.err = e_err;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    int nwr, ndone, done_at_wr;
    logic [TW-1:0] seen [4];

    initial begin
        //   rst st v  data last | rdy wr tap busy done err
        add(1, 0, 0,  0, 0,   0, 0,  0, 0, 0, 0);   // reset
        // full clean load 1..4
        add(0, 1, 0,  0, 0,   0, 0,  0, 0, 0, 0);
        add(0, 0, 1,  1, 0,   1, 0,  0, 1, 0, 0);
        add(0, 0, 1,  2, 0,   1, 1,  1, 1, 0, 0);
        add(0, 0, 1,  3, 0,   1, 1,  2, 1, 0, 0);
        add(0, 0, 1,  4, 1,   1, 1,  3, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0, 1,  4, 0, 1, 0);
        add(0, 0, 0,  0, 0,   0, 0,  4, 0, 0, 0);
        // short set 7,8 -> zero fill
        add(0, 1, 0,  0, 0,   0, 0,  4, 0, 0, 0);
        add(0, 0, 1,  7, 0,   1, 0,  4, 1, 0, 0);
        add(0, 0, 1,  8, 1,   1, 1,  7, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0, 1,  8, 1, 0, 1);
        add(0, 0, 0,  0, 0,   0, 1,  0, 1, 0, 1);
        add(0, 0, 0,  0, 0,   0, 1,  0, 0, 1, 1);
        add(0, 0, 0,  0, 0,   0, 0,  0, 0, 0, 1);
        // valid in IDLE ignored; long set 1..6 with stray i_start
        add(0, 0, 1,  9, 0,   0, 0,  0, 0, 0, 1);
        add(0, 1, 1,  9, 0,   0, 0,  0, 0, 0, 1);
        add(0, 0, 1,  1, 0,   1, 0,  0, 1, 0, 0);
        add(0, 1, 1,  2, 0,   1, 1,  1, 1, 0, 0);
        add(0, 0, 1,  3, 0,   1, 1,  2, 1, 0, 0);
        add(0, 0, 1,  4, 0,   1, 1,  3, 1, 0, 0);
        add(0, 0, 1,  5, 0,   1, 1,  4, 1, 0, 1);
        add(0, 1, 0,  0, 0,   1, 0,  4, 1, 0, 1);
        add(0, 0, 1,  6, 1,   1, 0,  4, 1, 0, 1);
        add(0, 0, 0,  0, 0,   0, 0,  4, 0, 1, 1);
        add(0, 0, 0,  0, 0,   0, 0,  4, 0, 0, 1);
        // valid gaps during LOAD
        add(0, 1, 0,  0, 0,   0, 0,  4, 0, 0, 1);
        add(0, 0, 1, 10, 0,   1, 0,  4, 1, 0, 0);
        add(0, 0, 0,  0, 0,   1, 1, 10, 1, 0, 0);
        add(0, 0, 0, 99, 1,   1, 0, 10, 1, 0, 0);
        add(0, 0, 1, 11, 0,   1, 0, 10, 1, 0, 0);
        add(0, 0, 0,  0, 0,   1, 1, 11, 1, 0, 0);
        add(0, 0, 1, 12, 0,   1, 0, 11, 1, 0, 0);
        add(0, 0, 0,  0, 0,   1, 1, 12, 1, 0, 0);
        add(0, 0, 1, 13, 1,   1, 0, 12, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0, 1, 13, 0, 1, 0);
        // reset mid-load, then clean reload
        add(0, 1, 0,  0, 0,   0, 0, 13, 0, 0, 0);
        add(0, 0, 1, 21, 0,   1, 0, 13, 1, 0, 0);
        add(0, 0, 1, 22, 0,   1, 1, 21, 1, 0, 0);
        add(1, 1, 1, 23, 1,   1, 1, 22, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  0, 0,   0, 0,  0, 0, 0, 0);
        add(0, 0, 1, 31, 0,   1, 0,  0, 1, 0, 0);
        add(0, 0, 1, 32, 0,   1, 1, 31, 1, 0, 0);
        add(0, 0, 1, 33, 0,   1, 1, 32, 1, 0, 0);
        add(0, 0, 1, 34, 1,   1, 1, 33, 1, 0, 0);
        add(0, 0, 0,  0, 0,   0, 1, 34, 0, 1, 0);
        add(0, 0, 0,  0, 0,   0, 0, 34, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; valid = vecs[i].valid;
            data = vecs[i].data; last = vecs[i].last;
            #1;
            chk("s_ready", i, 32'(ready),  32'(vecs[i].ready));
            chk("tap_wr",  i, 32'(tap_wr), 32'(vecs[i].wr));
            chk("tap",     i, 32'(tap),    32'(vecs[i].tap));
            chk("busy",    i, 32'(busy),   32'(vecs[i].busy));
            chk("done",    i, 32'(done),   32'(vecs[i].done));
            chk("err",     i, 32'(err),    32'(vecs[i].err));
        end

        // Single-beat set: s_last on the first beat forces three zero fills.
        @(negedge clk);
        rst = 0; start = 1; valid = 0; last = 0; data = '0;
        @(negedge clk);
        start = 0; valid = 1; data = 16'h0055; last = 1;
        @(negedge clk);
        valid = 0; last = 0; data = '0;
        nwr = 0; ndone = 0; done_at_wr = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (tap_wr) begin
                if (nwr < 4) seen[nwr] = tap;
                nwr++;
                if (done && nwr == NTAPS) done_at_wr = 1;
            end
            if (done) ndone++;
            @(negedge clk);
        end
        chk("zf_strobes", 0, 32'(nwr), 32'(NTAPS));
        chk("zf_first",   0, 32'(seen[0]), 32'h55);
        chk("zf_pad1",    0, 32'(seen[1]), 32'h0);
        chk("zf_pad3",    0, 32'(seen[3]), 32'h0);
        chk("zf_dones",   0, 32'(ndone), 32'd1);
        chk("zf_done_last", 0, 32'(done_at_wr), 32'd1);
        chk("zf_err",     0, 32'(err), 32'd1);
        chk("zf_busy",    0, 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
